ram_byte_responder: RTL and testbench
=====================================

// Module: ram_byte_responder
// PURPOSE
//  Responder end of the byte-serial CPU data-RAM port driven by the MEM stage.
//  Serves one read byte and/or one write byte per cycle from a byte array, with fixed registered read latency.
//  Sits between MEM and the storage array. Flags out-of-range accesses. Optionally decodes a memory-mapped output port.
// PARAMETERS
//  ADDR_W     17          byte-address bits actually decoded (array depth = DEPTH)
//  DEPTH      131072      array size in bytes; must be <= 2**ADDR_W
//  READ_LAT   1           posedges from address accepted to rdata valid; legal 1 or 2
//  INIT_FILE  ""          $readmemh image loaded at elaboration; "" = no load
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous reset, ACTIVE-LOW (rst==0 resets on posedge clk)
//  re_MEM_i      in   1   read request; address sampled every posedge it is high
//  raddr_MEM_i   in   32  read byte address
//  rdata_MEM_o   out  8   read data byte, registered
//  rvalid_o      out  1   1 for one cycle when rdata_MEM_o carries a fresh byte
//  we_MEM_i      in   1   write request; byte committed on posedge
//  waddr_MEM_i   in   32  write byte address
//  wdata_MEM_i   in   8   write data byte
//  err_o         out  1   sticky: any access with address >= DEPTH since reset
//  io_valid_o    out  1   (MEM_IO_PORT_EN only) 1-cycle strobe on IO write
//  io_data_o     out  8   (MEM_IO_PORT_EN only) byte written to IO_ADDR
// BEHAVIOUR
//  - Reset (rst==0 at posedge): rdata_MEM_o=8'h00, rvalid_o=0, err_o=0, io_valid_o=0, io_data_o=8'h00,
//    read pipeline valid bits cleared. Array contents NOT cleared. Reset mid-read drops the pending byte.
//  - Read, READ_LAT=1: re high at posedge k -> rdata_MEM_o=mem[raddr] and rvalid_o=1 after posedge k.
//    READ_LAT=2: one more register stage; data/valid after posedge k+1. Back-to-back reads every cycle are accepted.
//  - rdata_MEM_o HOLDS its last value when no new read completes; rvalid_o drops to 0.
//    The MEM stage samples 2 cycles after driving the address, so holding is mandatory.
//  - Write: we high at posedge -> mem[waddr] <= wdata. No response signal; zero added latency.
//  - Same-cycle read+write of the same address: write-first. The read returns wdata_MEM_i (bypass), not the old byte.
//    Different addresses: both proceed independently.
//  - Address decode uses addr[ADDR_W-1:0] only if addr < DEPTH (full 32-bit compare).
//    Otherwise: read returns 8'h00 with rvalid_o=1, write is dropped, err_o set and held until reset.
//  - re/we low: no array access, no state change except the read pipeline shifting.
//  - No state machine beyond the READ_LAT-deep valid/data pipeline. The responder never stalls the initiator.
// CONFIGURATION
//  MEM_IO_PORT_EN defined:
//    - A write to IO_ADDR (32'h0003_0000) is not stored in the array and is not flagged in err_o.
//    - io_data_o<=wdata, with io_valid_o=1 for exactly that cycle.
//    - A read of IO_ADDR returns 8'h00 with rvalid_o=1.
//  MEM_IO_PORT_EN undefined:
//    - io_valid_o/io_data_o ports absent.
//    - IO_ADDR is an ordinary address: out of range for the default DEPTH, so err_o is set.
// STRUCTURE
//  - macro.vh: IO_ADDR, ZeroWord, Enable/Disable, an 8'h00 ZeroByte constant, and READ_LAT legality check macro.
//  - Sub-module ram_byte_array holds the storage only: 1 write port, 1 synchronous read port, INIT_FILE load.
//  - ram_byte_responder holds range check, write-first bypass, latency pipeline, err/IO logic.
// TESTING
//  1. Reset: rst=0 two cycles with re=1 -> rdata=00, rvalid=0, err=0. Preloaded mem[0x10]=AB survives:
//     after rst=1, a read of 0x10 returns AB.
//  2. Write then read: we 0x100<=5A at cycle 0; re 0x100 at cycle 1 -> rdata=5A, rvalid=1 after the cycle-1 edge.
//     Next cycle rvalid=0 and rdata still 5A.
//  3. Collision: same edge we 0x200<=C3 and re 0x200 (old 11) -> rdata=C3. A later read of 0x200 also returns C3.
//  4. Stream: 4 consecutive reads 0x300..0x303 holding 01,02,03,04 ->
//     rdata sequence 01,02,03,04 on 4 consecutive cycles (READ_LAT=1).
//     With READ_LAT=2: same sequence, shifted one cycle.
//  5. Out of range: we to 0x0004_0000 -> array unchanged, err=1. err stays 1 across later legal accesses
//     until rst=0.
//  6. MEM_IO_PORT_EN: we 0x30000<=41 -> io_valid=1 one cycle, io_data=41, err=0.
//     Without the macro: same stimulus -> err=1.

Source files
------------

// File: rtl/ram_byte_responder_pkg.sv
// Shared constants, read-select encoding and address helpers for the byte-RAM responder.
// Used by ram_byte_responder; the optional IO port is enabled with MEM_IO_PORT_EN.
package ram_byte_responder_pkg;

    localparam logic [31:0] IoAddr   = 32'h0003_0000;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [7:0]  ZeroByte = 8'h00;
    localparam logic        Enable   = 1'b1;
    localparam logic        Disable  = 1'b0;

    // Source of the byte presented once a read leaves the first pipeline stage.
    typedef enum logic [1:0] {
        SelZero,
        SelArray,
        SelBypass
    } rd_sel_e;

    // Only latencies of 1 and 2 exist in hardware; anything else collapses to 1.
    function automatic int unsigned legal_read_lat(input int unsigned lat);
        return (lat == 2) ? 2 : 1;
    endfunction

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/ram_byte_responder_if.sv
// Byte-serial data-RAM port between the MEM stage (master) and the responder (slave).
// The io_valid/io_data pair exists only when MEM_IO_PORT_EN is defined.
interface ram_byte_responder_if;

    logic        re;
    logic [31:0] raddr;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        we;
    logic [31:0] waddr;
    logic [7:0]  wdata;
    logic        err;
`ifdef MEM_IO_PORT_EN
    logic        io_valid;
    logic [7:0]  io_data;
`endif

    modport master (
        output re, raddr, we, waddr, wdata,
        input  rdata, rvalid, err
`ifdef MEM_IO_PORT_EN
        , input io_valid, io_data
`endif
    );

    modport slave (
        input  re, raddr, we, waddr, wdata,
        output rdata, rvalid, err
`ifdef MEM_IO_PORT_EN
        , output io_valid, io_data
`endif
    );

endinterface

// File: rtl/ram_byte_array.sv
// Byte storage: one write port and one synchronous, enable-held read port.
// Read-during-write to the same address returns the old byte; the responder bypasses it.
module ram_byte_array #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DEPTH  = 131072
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // No reset: the output register only moves on a read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_byte_responder.sv
// Responder for the MEM-stage byte RAM port: range check, write-first bypass, read latency
// pipeline, sticky error flag and (with MEM_IO_PORT_EN defined) a memory-mapped output byte.
module ram_byte_responder
    import ram_byte_responder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned DEPTH    = 131072,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_byte_responder_if.slave  bus
);

    localparam int unsigned Lat = legal_read_lat(READ_LAT);

    logic    r_in, w_in;
    logic    r_io, w_io;
    logic    r_arr, w_store, bypass, oob_hit;
    rd_sel_e sel_d, sel_q;
    logic [7:0] byp_q;
    logic       v1_q;
    logic [7:0] arr_rdata;
    logic [7:0] d1;
    logic       err_q;

    always_comb begin
        r_in = addr_in_range(bus.raddr, DEPTH);
        w_in = addr_in_range(bus.waddr, DEPTH);
`ifdef MEM_IO_PORT_EN
        r_io = (bus.raddr == IoAddr);
        w_io = (bus.waddr == IoAddr);
`else
        r_io = Disable;
        w_io = Disable;
`endif
        r_arr   = bus.re && r_in && !r_io;
        w_store = bus.we && w_in && !w_io;
        bypass  = r_arr && w_store && (bus.waddr == bus.raddr);
        oob_hit = (bus.re && !r_in && !r_io) || (bus.we && !w_in && !w_io);

        sel_d = SelZero;
        if (bypass) begin
            sel_d = SelBypass;
        end else if (r_arr) begin
            sel_d = SelArray;
        end
    end

    ram_byte_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (w_store),
        .waddr (bus.waddr[ADDR_W-1:0]),
        .wdata (bus.wdata),
        .re    (r_arr),
        .raddr (bus.raddr[ADDR_W-1:0]),
        .rdata (arr_rdata)
    );

    // First stage: select and bypass byte only move on a read, so d1 holds between reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q <= SelZero;
            byp_q <= ZeroByte;
            v1_q  <= Disable;
            err_q <= Disable;
        end else begin
            v1_q  <= bus.re;
            err_q <= err_q | oob_hit;
            if (bus.re) begin
                sel_q <= sel_d;
            end
            if (bypass) begin
                byp_q <= bus.wdata;
            end
        end
    end

    always_comb begin
        d1 = ZeroByte;
        case (sel_q)
            SelArray:  d1 = arr_rdata;
            SelBypass: d1 = byp_q;
            default:   d1 = ZeroByte;
        endcase
    end

    generate
        if (Lat == 2) begin : g_lat2
            logic [7:0] data2_q;
            logic       v2_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    data2_q <= ZeroByte;
                    v2_q    <= Disable;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        data2_q <= d1;
                    end
                end
            end

            assign bus.rdata  = data2_q;
            assign bus.rvalid = v2_q;
        end else begin : g_lat1
            assign bus.rdata  = d1;
            assign bus.rvalid = v1_q;
        end
    endgenerate

    assign bus.err = err_q;

`ifdef MEM_IO_PORT_EN
    logic       io_valid_q;
    logic [7:0] io_data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            io_valid_q <= Disable;
            io_data_q  <= ZeroByte;
        end else begin
            io_valid_q <= bus.we && w_io;
            if (bus.we && w_io) begin
                io_data_q <= bus.wdata;
            end
        end
    end

    assign bus.io_valid = io_valid_q;
    assign bus.io_data  = io_data_q;
`endif

endmodule

// File: tb/tb_ram_byte_responder.sv
// Scoreboard bench for ram_byte_responder: driver pushes expectations from a reference model,
// an independent monitor pops and compares once per cycle. Honors MEM_IO_PORT_EN.
module tb_ram_byte_responder;

    localparam int unsigned AddrW   = 17;
    localparam int unsigned Depth   = 131072;
    localparam int unsigned ReadLat = 1;
    localparam logic [31:0] IoAdr   = 32'h0003_0000;

    typedef struct {
        bit         rst_act;
        logic       err;
        logic       io_valid;
        logic [7:0] io_data;
    } cyc_t;

    logic clk;
    logic rst;

    ram_byte_responder_if bus ();

    ram_byte_responder #(
        .ADDR_W   (AddrW),
        .DEPTH    (Depth),
        .READ_LAT (ReadLat)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [int unsigned];
    logic       err_m     = 1'b0;
    logic [7:0] io_data_m = 8'h00;
    logic [7:0] rd_q [$];
    cyc_t       cyc_q [$];
    logic [31:0] pool [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return a < Depth;
    endfunction

    function automatic bit is_io(input logic [31:0] a);
`ifdef MEM_IO_PORT_EN
        return a == IoAdr;
`else
        return (a == IoAdr) && 1'b0;
`endif
    endfunction

    // One bus cycle: inputs change at negedge, the DUT samples them at the following posedge.
    task automatic drive(input logic rst_v, input logic re, input logic [31:0] ra,
                         input logic we, input logic [31:0] wa, input logic [7:0] wd);
        cyc_t e;
        logic [7:0] rexp;
        @(negedge clk);
        rst       = rst_v;
        bus.re    = re;
        bus.raddr = ra;
        bus.we    = we;
        bus.waddr = wa;
        bus.wdata = wd;
        e.io_valid = 1'b0;
        if (!rst_v) begin
            err_m     = 1'b0;
            io_data_m = 8'h00;
        end else begin
            if (re) begin
                if (!in_rng(ra) || is_io(ra)) rexp = 8'h00;
                else if (we && wa == ra) rexp = wd;
                else rexp = mem_m[ra];
                rd_q.push_back(rexp);
            end
            if (re && !in_rng(ra) && !is_io(ra)) err_m = 1'b1;
            if (we && !in_rng(wa) && !is_io(wa)) err_m = 1'b1;
            if (we && is_io(wa)) begin
                e.io_valid = 1'b1;
                io_data_m  = wd;
            end
            if (we && in_rng(wa) && !is_io(wa)) mem_m[wa] = wd;
        end
        e.rst_act = !rst_v;
        e.err     = err_m;
        e.io_data = io_data_m;
        cyc_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        drive(1'b1, 1'b0, 32'h0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        drive(1'b1, 1'b1, a, 1'b0, 32'h0, 8'h00);
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k < 8) return pool[$urandom_range(0, 16)];
        if (k == 8) begin
            case ($urandom_range(0, 2))
                0:       return 32'h0002_0000;
                1:       return 32'h0004_0000;
                default: return {1'b1, 31'($urandom)};
            endcase
        end
        return IoAdr;
    endfunction

    // Monitor: one cycle record per posedge, read bytes popped whenever rvalid is high.
    logic [7:0] last_rd = 8'h00;
    always begin
        cyc_t e;
        logic [7:0] exp;
        @(posedge clk);
        #1;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            if (e.rst_act) begin
                rd_q.delete();
                last_rd = 8'h00;
                chk("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
                chk("rst_rdata", {24'b0, bus.rdata}, 32'h0);
            end else if (bus.rvalid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    chk("spurious_rvalid", {31'b0, bus.rvalid}, 32'h0);
                end else begin
                    exp = rd_q.pop_front();
                    chk("rdata", {24'b0, bus.rdata}, {24'b0, exp});
                    last_rd = exp;
                end
            end else begin
                chk("rvalid_known", {31'b0, bus.rvalid}, 32'h0);
                chk("rdata_hold", {24'b0, bus.rdata}, {24'b0, last_rd});
            end
            chk("err", {31'b0, bus.err}, {31'b0, e.err});
`ifdef MEM_IO_PORT_EN
            chk("io_valid", {31'b0, bus.io_valid}, {31'b0, e.io_valid});
            chk("io_data", {24'b0, bus.io_data}, {24'b0, e.io_data});
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        bus.re    = 1'b0;
        bus.raddr = 32'h0;
        bus.we    = 1'b0;
        bus.waddr = 32'h0;
        bus.wdata = 8'h00;
        for (int i = 0; i < 16; i++) pool[i] = 32'h1000 + i;
        pool[16] = Depth - 1;

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
        // Preload, then reset with reads pending: contents survive, output/flags clear.
        wr(32'h10, 8'hAB);
        for (int i = 0; i < 17; i++) wr(pool[i], 8'($urandom));
        wr(32'h200, 8'h11);
        for (int i = 0; i < 4; i++) wr(32'h300 + i, 8'(i + 1));
        rd(32'h10);
        rd(32'h1000);
        drive(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 8'h00);
        drive(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 8'h00);
        rd(32'h10);
        idle(2);

        wr(32'h100, 8'h5A);
        rd(32'h100);
        idle(2);

        drive(1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 8'hC3);
        idle(1);
        rd(32'h200);
        idle(2);

        for (int i = 0; i < 4; i++) rd(32'h300 + i);
        idle(3);

        wr(32'h0004_0000, 8'h77);
        rd(32'h0004_0000);
        rd(32'h100);
        wr(32'h101, 8'h66);
        rd(32'h101);
        rd(Depth);
        rd(Depth - 1);
        idle(2);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);

        wr(IoAdr, 8'h41);
        idle(1);
        rd(IoAdr);
        idle(2);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        w;
            logic [31:0] ra;
            logic [31:0] wa;
            r  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            ra = pick_addr();
            wa = ($urandom_range(0, 3) == 0) ? ra : pick_addr();
            if ($urandom_range(0, 149) == 0) drive(1'b0, r, ra, 1'b0, 32'h0, 8'h00);
            else drive(1'b1, r, ra, w, wa, 8'($urandom));
        end

        idle(4);
        @(posedge clk);
        #2;
        chk("reads_drained", rd_q.size(), 32'h0);
        chk("cycles_drained", cyc_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
